// File: rtl/countdown_pkg.sv
// countdown_pkg: shared types and defaults for the countdown controller.
//   state_e   - controller FSM state encoding
//   CD_WIDTH  - default counter width
//   CD_REP_W  - default repeat-count width
package countdown_pkg;

    localparam int CD_WIDTH = 4;
    localparam int CD_REP_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        DONE  = 2'b11
    } state_e;

endpackage

// File: rtl/load_down_counter.sv
// load_down_counter: loadable down-counter with enable.
//   clk, rst - clock, async active-high reset (q -> 0)
//   load, d  - synchronous load of d (load wins over en)
//   en       - decrement by one when high
//   q        - current value
//   zero     - q == 0
module load_down_counter
    import countdown_pkg::*;
#(
    parameter int WIDTH = CD_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             zero
);

    logic [WIDTH-1:0] q_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       q_q <= '0;
        else if (load) q_q <= d;
        else if (en)   q_q <= q_q - WIDTH'(1);
    end

    assign q    = q_q;
    assign zero = (q_q == '0);

endmodule

// File: rtl/countdown_controller.sv
// countdown_controller: sequences a loadable down-counter through one or
// more count-to-zero passes with pause/abort control.
//   clk, rst   - clock, async active-high reset
//   start      - run request, honoured only in IDLE or DONE
//   load_val   - start value, captured on accepted start
//   reps       - extra passes after the first, captured on accepted start
//   pause      - level; holds the count while high
//   abort      - level; forces IDLE, highest priority
//   count      - current counter value
//   busy       - high in RUN or PAUSE
//   tc         - one-cycle pulse per pass reaching terminal count
//   done       - high while in DONE
//   reps_left  - remaining reloads
module countdown_controller
    import countdown_pkg::*;
#(
    parameter int WIDTH = CD_WIDTH,
    parameter int REP_W = CD_REP_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] load_val,
    input  logic [REP_W-1:0] reps,
    input  logic             pause,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             tc,
    output logic             done,
    output logic [REP_W-1:0] reps_left
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] ld_q, ld_d;
    logic [REP_W-1:0] reps_q, reps_d;
    logic             tc_q, tc_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             cnt_load, cnt_en, cnt_zero;
    logic [WIDTH-1:0] cnt_d, cnt_q;

    load_down_counter #(.WIDTH(WIDTH)) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .load (cnt_load),
        .en   (cnt_en),
        .d    (cnt_d),
        .q    (cnt_q),
        .zero (cnt_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ld_q    <= '0;
            reps_q  <= '0;
            tc_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ld_q    <= ld_d;
            reps_q  <= reps_d;
            tc_q    <= tc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ld_d     = ld_q;
        reps_d   = reps_q;
        tc_d     = 1'b0;
        cnt_load = 1'b0;
        cnt_en   = 1'b0;
        cnt_d    = ld_q;

        if (abort) begin
            // Clear through the counter's load path rather than its reset.
            state_d  = IDLE;
            reps_d   = '0;
            cnt_load = 1'b1;
            cnt_d    = '0;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_d  = RUN;
                        ld_d     = load_val;
                        reps_d   = reps;
                        cnt_load = 1'b1;
                        cnt_d    = load_val;
                    end
                end
                RUN: begin
                    if (pause) begin
                        state_d = PAUSE;
                    end else if (!cnt_zero) begin
                        cnt_en = 1'b1;
                    end else begin
                        // Terminal edge: reload for another pass or finish.
                        tc_d = 1'b1;
                        if (reps_q != '0) begin
                            reps_d   = reps_q - REP_W'(1);
                            cnt_load = 1'b1;
                        end else begin
                            state_d = DONE;
                        end
                    end
                end
                PAUSE: begin
                    // Exit costs one cycle: count is held on the resume edge.
                    if (!pause) state_d = RUN;
                end
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d == RUN) || (state_d == PAUSE);
        done_d = (state_d == DONE);
    end

    assign count     = cnt_q;
    assign busy      = busy_q;
    assign tc        = tc_q;
    assign done      = done_q;
    assign reps_left = reps_q;

endmodule

// File: tb/tb_countdown_controller.sv
module tb_countdown_controller;

    localparam int W  = 4;
    localparam int RW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0, pause = 1'b0, abort = 1'b0;
    logic [W-1:0]  load_val = '0;
    logic [RW-1:0] reps = '0;
    logic [W-1:0]  count;
    logic          busy, tc, done;
    logic [RW-1:0] reps_left;

    always #5 clk = ~clk;

    countdown_controller #(.WIDTH(W), .REP_W(RW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .load_val  (load_val),
        .reps      (reps),
        .pause     (pause),
        .abort     (abort),
        .count     (count),
        .busy      (busy),
        .tc        (tc),
        .done      (done),
        .reps_left (reps_left)
    );

    typedef struct {
        int cnt;
        bit tc;
        bit busy;
        bit done;
        int rl;
    } exp_t;

    typedef struct {
        bit   s, a, p;
        int   ld, rp;
        exp_t e;
    } vec_t;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endtask

    task automatic chk_all(input string nm, input exp_t e);
        chk({nm, ".count"},     32'(count),     32'(e.cnt));
        chk({nm, ".tc"},        32'(tc),        32'(e.tc));
        chk({nm, ".busy"},      32'(busy),      32'(e.busy));
        chk({nm, ".done"},      32'(done),      32'(e.done));
        chk({nm, ".reps_left"}, 32'(reps_left), 32'(e.rl));
    endtask

    function automatic exp_t mke(int c, bit t, bit b, bit d, int rl);
        exp_t e;
        e.cnt = c; e.tc = t; e.busy = b; e.done = d; e.rl = rl;
        return e;
    endfunction

    function automatic vec_t mkv(bit s, bit a, bit p, int ld, int rp, exp_t e);
        vec_t v;
        v.s = s; v.a = a; v.p = p; v.ld = ld; v.rp = rp; v.e = e;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start = 0; abort = 0; pause = 0; load_val = '0; reps = '0;
    endtask

    // Reference: a run of value N with R reloads is R+1 passes; each pass is
    // the values N-1..0 after the start/reload edge, then a terminal edge with
    // tc. A pause of L cycles starting at edge j inserts L+1 held edges.
    task automatic run_trace(input string nm, input int n, input int r,
                             input bit do_pause, input int j, input int l,
                             input bit noisy);
        exp_t u[$];
        exp_t t[$];
        exp_t h;
        int   pl;
        u.push_back(mke(n, 0, 1, 0, r));
        for (int p = 0; p <= r; p++) begin
            for (int v = n - 1; v >= 0; v--) u.push_back(mke(v, 0, 1, 0, r - p));
            if (p < r) u.push_back(mke(n, 1, 1, 0, r - p - 1));
            else       u.push_back(mke(0, 1, 0, 1, 0));
        end
        pl = do_pause ? l : 0;
        for (int i = 0; i < u.size(); i++) begin
            if (do_pause && i == j) begin
                h = u[i-1];
                h.tc = 0;
                for (int k = 0; k <= l; k++) t.push_back(h);
            end
            t.push_back(u[i]);
        end
        for (int i = 0; i < t.size(); i++) begin
            start    = (i == 0) ? 1'b1 : (noisy ? 1'($urandom_range(0, 1)) : 1'b0);
            load_val = (i == 0) ? W'(n)  : W'($urandom);
            reps     = (i == 0) ? RW'(r) : RW'($urandom);
            pause    = do_pause && (i >= j) && (i < j + pl);
            tick();
            chk_all($sformatf("%s[%0d]", nm, i), t[i]);
        end
        idle_inputs();
        for (int i = 0; i < 2; i++) begin
            tick();
            chk_all($sformatf("%s.hold[%0d]", nm, i), mke(0, 0, 0, 1, 0));
        end
    endtask

    vec_t vt[$];

    initial begin
        // Per-edge table starting from IDLE.
        vt.push_back(mkv(1, 0, 0, 3, 0, mke(3, 0, 1, 0, 0)));
        vt.push_back(mkv(0, 0, 0, 0, 0, mke(2, 0, 1, 0, 0)));
        vt.push_back(mkv(0, 0, 0, 0, 0, mke(1, 0, 1, 0, 0)));
        vt.push_back(mkv(0, 0, 0, 0, 0, mke(0, 0, 1, 0, 0)));
        vt.push_back(mkv(0, 0, 0, 0, 0, mke(0, 1, 0, 1, 0)));
        vt.push_back(mkv(0, 0, 0, 0, 0, mke(0, 0, 0, 1, 0)));
        vt.push_back(mkv(1, 1, 0, 7, 2, mke(0, 0, 0, 0, 0)));  // start+abort in DONE
        vt.push_back(mkv(0, 0, 0, 0, 0, mke(0, 0, 0, 0, 0)));
        vt.push_back(mkv(1, 0, 0, 9, 3, mke(9, 0, 1, 0, 3)));
        vt.push_back(mkv(0, 0, 0, 0, 0, mke(8, 0, 1, 0, 3)));
        vt.push_back(mkv(1, 0, 0, 1, 0, mke(7, 0, 1, 0, 3)));  // start in RUN ignored
        vt.push_back(mkv(0, 1, 0, 0, 0, mke(0, 0, 0, 0, 0)));
        vt.push_back(mkv(1, 0, 0, 2, 1, mke(2, 0, 1, 0, 1)));
        vt.push_back(mkv(0, 0, 0, 0, 0, mke(1, 0, 1, 0, 1)));
        vt.push_back(mkv(0, 0, 0, 0, 0, mke(0, 0, 1, 0, 1)));
        vt.push_back(mkv(0, 1, 0, 0, 0, mke(0, 0, 0, 0, 0)));  // abort at count 0: no tc
        vt.push_back(mkv(0, 0, 1, 0, 0, mke(0, 0, 0, 0, 0)));

        #2;
        chk_all("reset", mke(0, 0, 0, 0, 0));
        #6 rst = 0;

        for (int i = 0; i < vt.size(); i++) begin
            start = vt[i].s; abort = vt[i].a; pause = vt[i].p;
            load_val = W'(vt[i].ld); reps = RW'(vt[i].rp);
            tick();
            chk_all($sformatf("vec[%0d]", i), vt[i].e);
        end
        idle_inputs();

        // Async reset mid-run at count 5.
        start = 1; load_val = 4'd9; reps = 4'd2;
        tick();
        idle_inputs();
        for (int i = 0; i < 4; i++) tick();
        chk("midrun.count_pre", 32'(count), 32'd5);
        #2 rst = 1;
        #1 chk_all("midrun_rst", mke(0, 0, 0, 0, 0));
        #1 rst = 0;

        // Directed corners through the reference model.
        run_trace("l2r2",   2, 2, 0, 0, 0, 0);
        run_trace("pause6", 6, 0, 1, 3, 3, 1);   // pause at count 4 for 3 cycles
        run_trace("l0r1",   0, 1, 0, 0, 0, 0);   // back-to-back tc
        run_trace("l15r0", 15, 0, 0, 0, 0, 0);

        // Randomised runs, chained from DONE.
        for (int r = 0; r < 25; r++) begin
            int n, rp, j, l, m;
            bit dp;
            n  = $urandom_range(0, 15);
            rp = $urandom_range(0, 3);
            m  = 1 + (rp + 1) * (n + 1);
            dp = 1'($urandom_range(0, 1));
            j  = $urandom_range(1, m - 1);
            l  = $urandom_range(1, 3);
            run_trace($sformatf("rnd%0d", r), n, rp, dp, j, l, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
